// File: rtl/div_nbits.sv
// Iterative N-bit integer divider, signed or unsigned, with RISC-V DIV/REM results.
// Restoring shift-subtract on operand magnitudes, one quotient bit per clock.
module div_nbits #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic [N-1:0] first_operand_i,
  input  logic [N-1:0] second_operand_i,
  input  logic         signed_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [N-1:0]   quo_reg, quo_next;
  logic [N:0]     rem_reg, rem_next;
  logic [N-1:0]   div_reg, div_next;
  logic           q_neg_reg, q_neg_next;
  logic           r_neg_reg, r_neg_next;
  logic           valid_reg, valid_next;
  logic [N-1:0]   quotient_reg, quotient_next;
  logic [N-1:0]   remainder_reg, remainder_next;

  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic           is_div_zero, is_overflow;
  logic [N+1:0]   trial;

  assign a_neg = signed_i & first_operand_i[N-1];
  assign b_neg = signed_i & second_operand_i[N-1];
  assign a_mag = a_neg ? (N'(0) - first_operand_i)  : first_operand_i;
  assign b_mag = b_neg ? (N'(0) - second_operand_i) : second_operand_i;

  assign is_div_zero = (second_operand_i == '0);
  assign is_overflow = signed_i && (first_operand_i == MIN_NEG) &&
                       (second_operand_i == {N{1'b1}});

  // Shift in the next dividend bit and trial-subtract; bit N+1 is the borrow.
  assign trial = {rem_reg, quo_reg[N-1]} - {2'b00, div_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      quo_reg       <= '0;
      rem_reg       <= '0;
      div_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      valid_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      quo_reg       <= quo_next;
      rem_reg       <= rem_next;
      div_reg       <= div_next;
      q_neg_reg     <= q_neg_next;
      r_neg_reg     <= r_neg_next;
      valid_reg     <= valid_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    quo_next       = quo_reg;
    rem_next       = rem_reg;
    div_next       = div_reg;
    q_neg_next     = q_neg_reg;
    r_neg_next     = r_neg_reg;
    valid_next     = 1'b0;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          // Special cases preload the final answer and skip the iteration.
          if (is_div_zero) begin
            state_next = DONE;
            quo_next   = {N{1'b1}};
            rem_next   = {1'b0, first_operand_i};
            q_neg_next = 1'b0;
            r_neg_next = 1'b0;
          end else if (is_overflow) begin
            state_next = DONE;
            quo_next   = first_operand_i;
            rem_next   = '0;
            q_neg_next = 1'b0;
            r_neg_next = 1'b0;
          end else begin
            state_next = CALC;
            quo_next   = a_mag;
            div_next   = b_mag;
            rem_next   = '0;
            cnt_next   = CW'(N - 1);
            q_neg_next = a_neg ^ b_neg;
            r_neg_next = a_neg;
          end
        end
      end

      CALC: begin
        if (trial[N+1]) begin
          rem_next = {rem_reg[N-1:0], quo_reg[N-1]};
          quo_next = {quo_reg[N-2:0], 1'b0};
        end else begin
          rem_next = trial[N:0];
          quo_next = {quo_reg[N-2:0], 1'b1};
        end
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end

      DONE: begin
        quotient_next  = q_neg_reg ? (N'(0) - quo_reg) : quo_reg;
        remainder_next = r_neg_reg ? (N'(0) - rem_reg[N-1:0]) : rem_reg[N-1:0];
        valid_next     = 1'b1;
        state_next     = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy_o      = (state_reg != IDLE);
  assign valid_o     = valid_reg;
  assign quotient_o  = quotient_reg;
  assign remainder_o = remainder_reg;

endmodule

// File: tb/tb_div_nbits.sv
// Directed self-checking bench for div_nbits at N=8.
module tb_div_nbits;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [N-1:0] first_operand_i;
  logic [N-1:0] second_operand_i;
  logic         signed_i;
  logic         busy_o;
  logic         valid_o;
  logic [N-1:0] quotient_o;
  logic [N-1:0] remainder_o;

  int n_cmp = 0;
  int n_bad = 0;

  div_nbits #(.N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .first_operand_i  (first_operand_i),
    .second_operand_i (second_operand_i),
    .signed_i         (signed_i),
    .busy_o           (busy_o),
    .valid_o          (valid_o),
    .quotient_o       (quotient_o),
    .remainder_o      (remainder_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (valid_o !== 1'b1 && lat < 30);
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic s, input logic [N-1:0] exp_q,
                         input logic [N-1:0] exp_r, input int exp_lat);
    int lat;
    start_i          = 1'b1;
    first_operand_i  = a;
    second_operand_i = b;
    signed_i         = s;
    tick();
    check({tag, " busy"}, 64'(busy_o), 64'd1);
    start_i          = 1'b0;
    first_operand_i  = N'($urandom);
    second_operand_i = N'($urandom);
    signed_i         = 1'($urandom);
    wait_valid(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " quotient"}, 64'(quotient_o), 64'(exp_q));
    check({tag, " remainder"}, 64'(remainder_o), 64'(exp_r));
    tick();
    check({tag, " valid pulse"}, 64'(valid_o), 64'd0);
    check({tag, " hold"}, 64'(quotient_o), 64'(exp_q));
    $display("txn %s: a=0x%02h b=0x%02h signed=%0b -> q=0x%02h r=0x%02h lat=%0d",
             tag, a, b, s, quotient_o, remainder_o, lat);
  endtask

  initial begin
    int lat;
    int seen;

    // Reset has priority over a concurrent start.
    reset            = 1'b1;
    start_i          = 1'b1;
    first_operand_i  = 8'd9;
    second_operand_i = 8'd3;
    signed_i         = 1'b0;
    repeat (3) tick();
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset valid", 64'(valid_o), 64'd0);
    check("reset quotient", 64'(quotient_o), 64'd0);
    check("reset remainder", 64'(remainder_o), 64'd0);
    reset   = 1'b0;
    start_i = 1'b0;
    tick();
    check("idle busy", 64'(busy_o), 64'd0);

    run_div("u100/7",     8'd100, 8'd7,   1'b0, 8'd14,  8'd2,    9);
    run_div("s-7/2",      8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF,   9);
    run_div("s7/-2",      8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01,   9);
    run_div("u55/0",      8'h55,  8'h00,  1'b0, 8'hFF,  8'h55,   1);
    run_div("s55/0",      8'h55,  8'h00,  1'b1, 8'hFF,  8'h55,   1);
    run_div("s80/FF",     8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,   1);
    run_div("u80/FF",     8'h80,  8'hFF,  1'b0, 8'h00,  8'h80,   9);
    run_div("s80/1",      8'h80,  8'h01,  1'b1, 8'h80,  8'h00,   9);
    run_div("uFF/1",      8'hFF,  8'h01,  1'b0, 8'hFF,  8'h00,   9);
    run_div("s-100/-7",   8'h9C,  8'hF9,  1'b1, 8'h0E,  8'hFE,   9);

    // start held high with changing operands: only the first request is taken.
    start_i          = 1'b1;
    first_operand_i  = 8'd50;
    second_operand_i = 8'd5;
    signed_i         = 1'b0;
    tick();
    lat = 0;
    do begin
      first_operand_i  = N'($urandom);
      second_operand_i = N'($urandom);
      signed_i         = 1'($urandom);
      tick();
      lat++;
    end while (valid_o !== 1'b1 && lat < 30);
    check("held latency", 64'(lat), 64'd9);
    check("held quotient", 64'(quotient_o), 64'd10);
    check("held remainder", 64'(remainder_o), 64'd0);
    check("held idle gap", 64'(busy_o), 64'd0);
    $display("txn held: 50/5 -> q=%0d r=%0d lat=%0d", quotient_o, remainder_o, lat);
    first_operand_i  = 8'd9;
    second_operand_i = 8'd2;
    signed_i         = 1'b0;
    tick();
    check("held reaccept", 64'(busy_o), 64'd1);
    start_i = 1'b0;
    wait_valid(lat);
    check("held2 latency", 64'(lat), 64'd9);
    check("held2 quotient", 64'(quotient_o), 64'd4);
    check("held2 remainder", 64'(remainder_o), 64'd1);
    $display("txn held2: 9/2 -> q=%0d r=%0d lat=%0d", quotient_o, remainder_o, lat);

    // Reset mid-calculation aborts with no result pulse.
    start_i          = 1'b1;
    first_operand_i  = 8'd200;
    second_operand_i = 8'd3;
    signed_i         = 1'b0;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 64'(busy_o), 64'd0);
    check("abort quotient", 64'(quotient_o), 64'd0);
    check("abort remainder", 64'(remainder_o), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_o === 1'b1) seen++;
      tick();
    end
    check("abort no valid", 64'(seen), 64'd0);
    $display("txn abort: 200/3 reset after 4 cycles, valid pulses seen=%0d", seen);
    run_div("u9/3",       8'd9,   8'd3,   1'b0, 8'd3,   8'd0,    9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_nbits.md
DIV_NBITS -- requirements
Module: div_nbits

Interface
REQ-001 Parameter N, default 32, operand and result width in bits; legal values 2..64.
REQ-002 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1, synchronous, active-high reset.
REQ-004 Port start_i, input, 1, request to begin a division; sampled only when busy_o is low.
REQ-005 Port first_operand_i, input, N, dividend; captured on acceptance.
REQ-006 Port second_operand_i, input, N, divisor; captured on acceptance.
REQ-007 Port signed_i, input, 1, signedness: 1 treats both operands as two's complement, 0 treats both as unsigned; captured on acceptance.
REQ-008 Port busy_o, output, 1, high while a division is in progress.
REQ-009 Port valid_o, output, 1, single-cycle pulse marking a completed result.
REQ-010 Port quotient_o, output, N, quotient of the last completed division.
REQ-011 Port remainder_o, output, N, remainder of the last completed division.

Function
REQ-012 The block SHALL have three states: IDLE, CALC and DONE.
REQ-013 Acceptance SHALL occur when start_i=1 and busy_o=0; start_i in any other cycle SHALL be ignored and SHALL NOT disturb the running operation.
REQ-014 busy_o SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-015 On acceptance with normal operands, the block SHALL go IDLE->CALC and store the operand magnitudes: the absolute value when signed_i=1 and the MSB is 1, otherwise the raw value.
REQ-016 The block SHALL also store the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a).
REQ-017 CALC SHALL perform restoring shift-subtract, one quotient bit per cycle, MSB first, with an (N+1)-bit partial remainder, for exactly N cycles counted by a down-counter.
REQ-018 After the last CALC cycle the block SHALL enter DONE.
REQ-019 In DONE, the block SHALL negate the quotient if the quotient sign is set and negate the remainder if the remainder sign is set, modulo 2^N.
REQ-020 In DONE, the block SHALL register the results to quotient_o and remainder_o, assert valid_o for that one cycle, and return to IDLE.
REQ-021 Normal latency: valid_o SHALL be 1 exactly N+1 cycles after the acceptance edge.
REQ-022 Back-to-back throughput: the next acceptance SHALL be possible no earlier than N+2 cycles after the previous one.
REQ-023 Divide by zero (divisor=0, either mode) SHALL go IDLE->DONE directly with quotient_o=all ones and remainder_o=dividend.
REQ-024 Signed overflow (signed_i=1, dividend=2^(N-1), divisor=all ones) SHALL go IDLE->DONE directly with quotient_o=dividend and remainder_o=0.
REQ-025 Special-case latency (REQ-023, REQ-024): valid_o SHALL be 1 one cycle after the acceptance edge.
REQ-026 Signed results SHALL truncate toward zero, and the remainder SHALL take the dividend's sign, per RISC-V M DIV/REM semantics.
REQ-027 quotient_o and remainder_o SHALL change only in DONE and SHALL otherwise hold their last value.
REQ-028 Operand inputs SHALL be ignored outside the acceptance cycle; changes mid-operation SHALL have no effect.

Reset
REQ-029 While reset=1 at a clock edge, the block SHALL enter IDLE with busy_o=0, valid_o=0, quotient_o=0, remainder_o=0, and the counter and partial remainder cleared.
REQ-030 Reset SHALL take priority over start_i in the same cycle.
REQ-031 Reset during CALC or DONE SHALL abort the operation with no valid_o pulse afterwards.
REQ-032 After reset deasserts, the first start_i SHALL be accepted.

Verification (N=8)
REQ-033 Unsigned 100/7 (signed_i=0) -> valid_o 9 cycles after acceptance, quotient_o=14, remainder_o=2.
REQ-034 Signed 0xF9/0x02 (-7/2) -> quotient_o=0xFD (-3), remainder_o=0xFF (-1); signed 7/0xFE -> quotient_o=0xFD, remainder_o=0x01.
REQ-035 Divide by zero, 0x55/0x00 in both modes -> valid_o 1 cycle after acceptance, quotient_o=0xFF, remainder_o=0x55.
REQ-036 Signed 0x80/0xFF -> quotient_o=0x80, remainder_o=0x00 after 1 cycle; unsigned 0x80/0xFF -> quotient_o=0, remainder_o=0x80 after 9 cycles.
REQ-037 start_i held high continuously with changing operands -> only the first request is accepted, its result is correct, and the next acceptance comes 10 cycles later.
REQ-038 Reset asserted 4 cycles into 200/3 -> no valid_o pulse, outputs read 0, and a following 9/3 yields quotient_o=3, remainder_o=0.
